// File: rtl/text_line_writer.sv
// One-line text buffer for an overlay renderer: commands edit a working line, which is copied
// to the displayed word only on a vsync falling edge so the picture never tears mid-frame.
module text_line_writer #(
  parameter int         LENGTH    = 32,
  parameter logic [7:0] TERM_CHAR = 8'h7E
) (
  input  logic                       iVGA_CLK,
  input  logic                       iRST_n,
  input  logic                       cVS,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_cmd,
  input  logic [7:0]                 in_char,
  output logic [0:(LENGTH+1)*8-1]    word,
  output logic [7:0]                 count,
  output logic                       full,
  output logic                       overflow,
  output logic                       dirty
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  localparam logic [7:0] LEN8  = 8'(LENGTH);

  logic [0:0]             state_q, state_d;
  logic [7:0]             clr_q, clr_d;
  logic [7:0]             count_q, count_d;
  logic                   dirty_q, dirty_d;
  logic                   ovf_q, ovf_d;
  logic                   vs_q, pub_q;
  logic [LENGTH:0][7:0]   buf_q, buf_d;
  logic [LENGTH:0][7:0]   shd_q, shd_d;
  logic                   accept;
  logic                   publish;
  logic [7:0]             ch;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign publish  = pub_q && dirty_q && (state_q == IDLE);
  // NUL and the terminator are remapped so the terminator stays unique in the line
  assign ch       = (in_char == 8'h00 || in_char == TERM_CHAR) ? 8'h20 : in_char;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    count_d = count_q;
    dirty_d = dirty_q;
    ovf_d   = 1'b0;
    buf_d   = buf_q;
    shd_d   = shd_q;

    // Publish sees the pre-command buffer; a same-cycle edit re-marks dirty below
    if (publish) begin
      shd_d   = buf_q;
      dirty_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (in_cmd)
            2'b00: begin
              if (count_q < LEN8) begin
                for (int i = 0; i <= LENGTH; i++) begin
                  if (8'(i) == count_q)         buf_d[i] = ch;
                  if (8'(i) == count_q + 8'd1)  buf_d[i] = TERM_CHAR;
                end
                count_d = count_q + 8'd1;
                dirty_d = 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
            2'b01: begin
              if (count_q != 8'd0) begin
                for (int i = 0; i <= LENGTH; i++) begin
                  if (8'(i) == count_q - 8'd1)  buf_d[i] = TERM_CHAR;
                  if (8'(i) == count_q)         buf_d[i] = 8'h00;
                end
                count_d = count_q - 8'd1;
                dirty_d = 1'b1;
              end
            end
            2'b10: begin
              state_d = CLEAR;
              clr_d   = 8'd0;
            end
            default: ;
          endcase
        end
      end
      default: begin
        for (int i = 0; i <= LENGTH; i++) begin
          if (8'(i) == clr_q) buf_d[i] = 8'h00;
        end
        if (clr_q == LEN8) begin
          buf_d[0] = TERM_CHAR;
          count_d  = 8'd0;
          dirty_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          clr_d = clr_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      clr_q   <= 8'd0;
      count_q <= 8'd0;
      dirty_q <= 1'b0;
      ovf_q   <= 1'b0;
      vs_q    <= 1'b1;
      pub_q   <= 1'b0;
      for (int i = 0; i <= LENGTH; i++) begin
        buf_q[i] <= (i == 0) ? TERM_CHAR : 8'h00;
        shd_q[i] <= (i == 0) ? TERM_CHAR : 8'h00;
      end
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      count_q <= count_d;
      dirty_q <= dirty_d;
      ovf_q   <= ovf_d;
      vs_q    <= cVS;
      pub_q   <= vs_q && !cVS;
      buf_q   <= buf_d;
      shd_q   <= shd_d;
    end
  end

  for (genvar g = 0; g <= LENGTH; g++) begin : g_word
    assign word[8*g +: 8] = shd_q[g];
  end

  assign count    = count_q;
  assign full     = (count_q == LEN8);
  assign overflow = ovf_q;
  assign dirty    = dirty_q;

endmodule
